dram_ctrl: RTL and testbench

Parametrised single-port data RAM with a valid/ready request interface, registered read data, byte-enable writes, address-window checking and an optional post-reset clear sequence. It sits behind the memory-mapped I/O decoder. Addresses below the port window base belong to I/O ports and are not stored here. It replaces the unclocked-read, negedge-write data RAM.

---
 rtl/dram_pkg.sv | 15 +
 rtl/dram_array.sv | 38 +++
 rtl/dram_ctrl.sv | 159 +++++++++++++++
 tb/tb_dram_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared types and default geometry for the data RAM behind the I/O decoder.
// Addresses below DEF_BASE decode to I/O ports (two words per port).
package dram_pkg;

  localparam int PORT_EXPONENT = 2;
  localparam int DEF_BASE      = 2 * (1 << PORT_EXPONENT);
  localparam int DEF_LIMIT     = 32767;
  localparam int DEF_DATA_W    = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } dram_state_e;

endpackage

// File: rtl/dram_array.sv
// Single-port synchronous word array, byte-enable write, registered read (1 cycle).
// No flow control of its own; the caller issues at most one access per cycle.
module dram_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 4
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [IDX_W-1:0]    addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int BE_W = DATA_W / 8;

  // Contents and read register carry no reset so a vendor macro can drop in.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (en && !we) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dram_ctrl.sv
// Windowed data RAM: valid/ready requests, response two edges after accept (accept N, visible after N+1).
// One request per cycle in IDLE, none while clearing; responses have no backpressure.
module dram_ctrl
  import dram_pkg::*;
#(
  parameter int    DATA_W         = DEF_DATA_W,
  parameter int    ADDR_W         = 16,
  parameter int    BASE           = DEF_BASE,
  parameter int    LIMIT          = DEF_LIMIT,
  parameter bit    CLEAR_ON_RESET = 1'b1,
  parameter string INIT_FILE      = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy
);

  localparam int DEPTH = LIMIT - BASE + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W  = DATA_W / 8;

  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LIMIT_A = ADDR_W'(LIMIT);
  localparam logic [IDX_W-1:0]  LAST_IX = IDX_W'(DEPTH - 1);

  dram_state_e       state_q, state_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;

  // Stage 1: request accepted, array access in flight.
  logic              s1_vld_q, s1_vld_d;
  logic              s1_err_q, s1_err_d;
  logic              s1_rd_q,  s1_rd_d;

  // Stage 2: response registers driving the outputs.
  logic              rsp_vld_q,   rsp_vld_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              arr_en;
  logic              arr_we;
  logic [BE_W-1:0]   arr_be;
  logic [IDX_W-1:0]  arr_addr;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;

  logic              in_range;
  logic              accept;
  logic [IDX_W-1:0]  req_idx;

  assign in_range  = (req_addr >= BASE_A) && (req_addr <= LIMIT_A);
  assign req_idx   = IDX_W'(req_addr - BASE_A);
  // Gating with rst_n keeps ready low during reset even when reset lands in IDLE.
  assign req_ready = rst_n && (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLEAR);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    s1_vld_d  = 1'b0;
    s1_err_d  = 1'b0;
    s1_rd_d   = 1'b0;
    arr_en    = 1'b0;
    arr_we    = 1'b0;
    arr_be    = '0;
    arr_addr  = clr_idx_q;
    arr_wdata = '0;

    case (state_q)
      ST_CLEAR: begin
        arr_en = 1'b1;
        arr_we = 1'b1;
        arr_be = '1;
        if (clr_idx_q == LAST_IX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          s1_vld_d = 1'b1;
          if (in_range) begin
            arr_en    = 1'b1;
            arr_we    = req_write;
            arr_be    = req_be;
            arr_addr  = req_idx;
            arr_wdata = req_wdata;
            s1_rd_d   = !req_write;
          end else begin
            s1_err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rsp_vld_d   = s1_vld_q;
    rsp_err_d   = s1_err_q;
    rsp_rdata_d = s1_rd_q ? arr_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        state_q <= ST_CLEAR;
      end else begin
        state_q <= ST_IDLE;
      end
      clr_idx_q   <= '0;
      s1_vld_q    <= 1'b0;
      s1_err_q    <= 1'b0;
      s1_rd_q     <= 1'b0;
      rsp_vld_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      s1_vld_q    <= s1_vld_d;
      s1_err_q    <= s1_err_d;
      s1_rd_q     <= s1_rd_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  dram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .be    (arr_be),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_dram_ctrl.sv
// Directed bench for dram_ctrl with a 16-word window at 8..23 and clear-on-reset.
module tb_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dram_ctrl #(
    .DATA_W         (16),
    .ADDR_W         (16),
    .BASE           (8),
    .LIMIT          (23),
    .CLEAR_ON_RESET (1'b1),
    .INIT_FILE      ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs while busy (bounded); reports cycles spent busy and any ready/valid seen meanwhile.
  task automatic measure_clear(output int cyc, output int rdy_seen, output int vld_seen);
    cyc = 0;
    rdy_seen = 0;
    vld_seen = 0;
    while (busy && cyc < 64) begin
      if (req_ready) rdy_seen++;
      if (rsp_valid) vld_seen++;
      step();
      cyc++;
    end
  endtask

  // Single non-overlapped request: accept edge, response after the next edge, then gone.
  task automatic do_req(input string tag, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [1:0] be,
                        input logic [15:0] exp_d, input logic exp_e);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    step();
    req_valid = 1'b0;
    step();
    check({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_dat"}, {16'd0, rsp_rdata}, {16'd0, exp_d});
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_e});
    step();
    check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cyc, rdy_seen, vld_seen;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;

    step();
    step();
    check("rst_busy",  {31'd0, busy},      32'd1);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_vld",   {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
    check("rst_err",   {31'd0, rsp_err},   32'd0);

    rst_n = 1'b1;
    measure_clear(cyc, rdy_seen, vld_seen);
    check("clr_len",       cyc,      32'd16);
    check("clr_rdy_seen",  rdy_seen, 32'd0);
    check("clr_ready_end", {31'd0, req_ready}, 32'd1);

    for (int a = 8; a <= 23; a++) begin
      do_req($sformatf("zero_%0d", a), 1'b0, 16'(a), 16'h0, 2'b00, 16'h0000, 1'b0);
    end

    // Write then read the same word on the very next cycle.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_wdata = 16'hBEEF; req_be = 2'b11;
    step();
    req_write = 1'b0; req_wdata = 16'h0000;
    step();
    req_valid = 1'b0;
    check("b2b_wr_vld", {31'd0, rsp_valid}, 32'd1);
    check("b2b_wr_dat", {16'd0, rsp_rdata}, 32'd0);
    step();
    check("b2b_rd_vld", {31'd0, rsp_valid}, 32'd1);
    check("b2b_rd_dat", {16'd0, rsp_rdata}, 32'h0000BEEF);
    check("b2b_rd_err", {31'd0, rsp_err},   32'd0);
    step();

    do_req("be01_wr", 1'b1, 16'h0010, 16'h12AB, 2'b01, 16'h0000, 1'b0);
    do_req("be01_rd", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAB, 1'b0);
    do_req("be00_wr", 1'b1, 16'h0010, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
    do_req("be00_rd", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAB, 1'b0);
    do_req("be10_wr", 1'b1, 16'h0011, 16'h5AC3, 2'b10, 16'h0000, 1'b0);
    do_req("be10_rd", 1'b0, 16'h0011, 16'h0000, 2'b00, 16'h5A00, 1'b0);

    do_req("oor07_rd", 1'b0, 16'h0007, 16'h0000, 2'b00, 16'h0000, 1'b1);
    do_req("oor18_rd", 1'b0, 16'h0018, 16'h0000, 2'b00, 16'h0000, 1'b1);
    do_req("oor07_wr", 1'b1, 16'h0007, 16'hDEAD, 2'b11, 16'h0000, 1'b1);
    do_req("oor18_wr", 1'b1, 16'h0018, 16'hCAFE, 2'b11, 16'h0000, 1'b1);
    do_req("oorFF_rd", 1'b0, 16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1);
    do_req("oor_keep23", 1'b0, 16'h0017, 16'h0000, 2'b00, 16'h0000, 1'b0);
    do_req("oor_keep08", 1'b0, 16'h0008, 16'h0000, 2'b00, 16'h0000, 1'b0);
    do_req("oor_keep10", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEAB, 1'b0);

    for (int a = 8; a <= 15; a++) begin
      do_req($sformatf("fill_%0d", a), 1'b1, 16'(a), 16'h0100 + 16'(a), 2'b11, 16'h0000, 1'b0);
    end

    // Streamed reads: response of request i-1 is visible right after accept edge of request i.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'(8 + i); req_be = 2'b00;
      end else begin
        req_valid = 1'b0;
      end
      step();
      if (i == 0) begin
        check("strm_first_idle", {31'd0, rsp_valid}, 32'd0);
      end else begin
        check($sformatf("strm_vld_%0d", i - 1), {31'd0, rsp_valid}, 32'd1);
        check($sformatf("strm_dat_%0d", i - 1), {16'd0, rsp_rdata}, 32'h0108 + 32'(i - 1));
      end
    end
    step();
    check("strm_end", {31'd0, rsp_valid}, 32'd0);

    // Reset while one response is showing and another is in flight.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
    step();
    req_addr = 16'h0009;
    step();
    req_valid = 1'b0;
    check("drop_pre_vld", {31'd0, rsp_valid}, 32'd1);
    check("drop_pre_dat", {16'd0, rsp_rdata}, 32'h0000BEAB);
    #2;
    rst_n = 1'b0;
    #1;
    check("drop_async_vld", {31'd0, rsp_valid}, 32'd0);
    check("drop_async_dat", {16'd0, rsp_rdata}, 32'd0);
    check("drop_ready",     {31'd0, req_ready}, 32'd0);
    step();
    rst_n = 1'b1;
    measure_clear(cyc, rdy_seen, vld_seen);
    check("drop_clr_len",  cyc,      32'd16);
    check("drop_no_rsp",   vld_seen, 32'd0);
    check("drop_rdy_seen", rdy_seen, 32'd0);

    // Reset when the clear counter has reached index 5.
    do_req("pre_mid_wr", 1'b1, 16'h0008, 16'h7777, 2'b11, 16'h0000, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  {31'd0, busy},      32'd1);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    measure_clear(cyc, rdy_seen, vld_seen);
    check("mid_clr_len", cyc, 32'd16);
    check("mid_no_rsp",  vld_seen, 32'd0);

    do_req("post_08", 1'b0, 16'h0008, 16'h0000, 2'b00, 16'h0000, 1'b0);
    do_req("post_10", 1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0000, 1'b0);
    do_req("post_17", 1'b0, 16'h0017, 16'h0000, 2'b00, 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
